// File: rtl/dma_burst_engine.sv
// Burst engine moving word blocks between system memory and the
// 512-word scratch SRAM over the shared bus.
module dma_burst_engine #(
    parameter int MAX_BURST = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        direction,
    input  logic [31:0] bus_start_address,
    input  logic [8:0]  memory_start_address,
    input  logic [9:0]  block_size,
    input  logic [7:0]  burst_size,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  sram_address,
    output logic        sram_write_enable,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data,
    output logic        busOut_request,
    input  logic        busIn_grants,
    output logic        busOut_begin_transaction,
    output logic [31:0] busOut_address_data,
    output logic [7:0]  busOut_burst_size,
    output logic [3:0]  busOut_byte_enable,
    output logic        busOut_read_n_write,
    output logic        busOut_data_valid,
    output logic        busOut_end_transaction,
    input  logic [31:0] busIn_address_data,
    input  logic        busIn_data_valid,
    input  logic        busIn_end_transaction,
    input  logic        busIn_busy,
    input  logic        busIn_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQUEST, S_BEGIN, S_READ_DATA,
        S_WRITE_DATA, S_WRITE_END, S_GAP, S_DONE
    } state_t;

    localparam logic [9:0] MAX_LEN = 10'(MAX_BURST);

    state_t      state, next;
    logic        dir_q;
    logic [31:0] bus_addr;
    logic [8:0]  sram_addr;
    logic [9:0]  remaining;
    logic [7:0]  burst_q;
    logic [9:0]  len_q;
    logic [9:0]  beats;

    logic [9:0]  len_c;
    logic [9:0]  rem_next;
    logic        rd_beat;
    logic        wr_acc;
    logic        step;
    logic        abort;

    always_comb begin
        len_c = {2'b00, burst_q} + 10'd1;
        if (len_c > MAX_LEN) len_c = MAX_LEN;
        if (len_c > remaining) len_c = remaining;
    end

    // An erroring cycle never commits a beat on either side.
    assign rd_beat = (state == S_READ_DATA) && busIn_data_valid && !busIn_error;
    assign wr_acc  = (state == S_WRITE_DATA) && !busIn_busy && !busIn_error;
    assign step     = rd_beat || wr_acc;
    assign rem_next = remaining - {9'd0, step};
    assign abort    = busIn_error && (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:
                if (start) next = (block_size == 10'd0) ? S_DONE : S_REQUEST;
            S_REQUEST:
                if (busIn_grants) next = S_BEGIN;
            S_BEGIN:
                next = dir_q ? S_WRITE_DATA : S_READ_DATA;
            S_READ_DATA:
                if (busIn_end_transaction)
                    next = (rem_next == 10'd0) ? S_DONE : S_GAP;
            S_WRITE_DATA:
                if (wr_acc && (beats == len_q - 10'd1)) next = S_WRITE_END;
            S_WRITE_END:
                next = (remaining == 10'd0) ? S_DONE : S_GAP;
            S_GAP:
                next = S_REQUEST;
            S_DONE:
                next = S_IDLE;
            default:
                next = S_IDLE;
        endcase
        if (abort) next = S_DONE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir_q     <= 1'b0;
            bus_addr  <= 32'd0;
            sram_addr <= 9'd0;
            remaining <= 10'd0;
            burst_q   <= 8'd0;
            len_q     <= 10'd0;
            beats     <= 10'd0;
            error     <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                dir_q     <= direction;
                bus_addr  <= {bus_start_address[31:2], 2'b00};
                sram_addr <= memory_start_address;
                remaining <= block_size;
                burst_q   <= burst_size;
                error     <= 1'b0;
            end
            if (state == S_BEGIN) begin
                len_q <= len_c;
                beats <= 10'd0;
            end
            if (step) begin
                sram_addr <= sram_addr + 9'd1;
                remaining <= rem_next;
                beats     <= beats + 10'd1;
            end
            if (state == S_GAP) bus_addr <= bus_addr + {20'd0, len_q, 2'b00};
            if (abort) error <= 1'b1;
        end
    end

    always_comb begin
        busy                     = 1'b0;
        done                     = 1'b0;
        sram_address             = 9'd0;
        sram_write_enable        = 1'b0;
        sram_write_data          = 32'd0;
        busOut_request           = 1'b0;
        busOut_begin_transaction = 1'b0;
        busOut_address_data      = 32'd0;
        busOut_burst_size        = 8'd0;
        busOut_byte_enable       = 4'h0;
        busOut_read_n_write      = 1'b0;
        busOut_data_valid        = 1'b0;
        busOut_end_transaction   = 1'b0;
        unique case (state)
            S_REQUEST: begin
                busy           = 1'b1;
                busOut_request = 1'b1;
            end
            S_BEGIN: begin
                busy                     = 1'b1;
                busOut_request           = 1'b1;
                busOut_begin_transaction = 1'b1;
                busOut_address_data      = bus_addr;
                busOut_burst_size        = 8'(len_c - 10'd1);
                busOut_byte_enable       = 4'hF;
                busOut_read_n_write      = ~dir_q;
                if (dir_q) sram_address = sram_addr;
            end
            S_READ_DATA: begin
                busy              = 1'b1;
                busOut_request    = 1'b1;
                sram_address      = sram_addr;
                sram_write_enable = rd_beat;
                if (rd_beat) sram_write_data = busIn_address_data;
            end
            S_WRITE_DATA: begin
                // Re-issuing the current address while stalled keeps the word stable.
                busy                = 1'b1;
                busOut_request      = 1'b1;
                busOut_data_valid   = 1'b1;
                busOut_address_data = sram_read_data;
                sram_address        = wr_acc ? sram_addr + 9'd1 : sram_addr;
            end
            S_WRITE_END: begin
                busy                   = 1'b1;
                busOut_request         = 1'b1;
                busOut_end_transaction = 1'b1;
            end
            S_GAP:  busy = 1'b1;
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/dma_burst_engine.md
# dma_burst_engine

Bus-master burst engine that moves a block of 32-bit words between system memory and the 512-word on-chip scratch SRAM of the DMA custom-instruction block. It sits between the DMA control registers and the shared bus. It takes a parameter set and a start pulse. It splits the block into bursts, arbitrates for the bus, and drives the scratch SRAM port. It reports busy/done/error back to the control registers.

## Interface
Parameters:
- MAX_BURST, 256: hardware limit on words per burst; `burst_size+1` is clipped to this value.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs
- start  in  1  one-cycle pulse; captures parameters when idle
- direction  in  1  0 = bus→SRAM (read bursts), 1 = SRAM→bus (write bursts)
- bus_start_address  in  32  word address on bus; bits [1:0] forced to 0
- memory_start_address  in  9  first SRAM word
- block_size  in  10  total words; 0 = no transfer
- burst_size  in  8  words per burst minus 1
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at completion or abort
- error  out  1  sticky; set on bus error, cleared by next accepted start
- sram_address  out  9  SRAM port address
- sram_write_enable  out  1  SRAM write strobe
- sram_write_data  out  32  SRAM write data
- sram_read_data  in  32  SRAM read data; valid one cycle after address
- busOut_request  out  1  bus request
- busIn_grants  in  1  bus grant
- busOut_begin_transaction  out  1  one-cycle transaction start
- busOut_address_data  out  32  address during begin, data during write beats
- busOut_burst_size  out  8  beats in this burst minus 1
- busOut_byte_enable  out  4  4'hF during begin, else 0
- busOut_read_n_write  out  1  1 = read burst
- busOut_data_valid  out  1  write beat valid
- busOut_end_transaction  out  1  one-cycle end of write burst
- busIn_address_data  in  32  read beat data
- busIn_data_valid  in  1  read beat valid
- busIn_end_transaction  in  1  slave end of read burst
- busIn_busy  in  1  slave stall for write beats
- busIn_error  in  1  bus error, aborts transfer

## Operation
- States: IDLE, REQUEST, BEGIN, READ_DATA, WRITE_DATA, WRITE_END, GAP, DONE.
- IDLE: on start, latch all parameters. Set `remaining = block_size`. Clear error. If `block_size==0`, go to DONE. Otherwise go to REQUEST. Start while busy is ignored.
- REQUEST: busOut_request=1 until busIn_grants=1, then go to BEGIN. Request stays high through the end of the burst.
- BEGIN (1 cycle): begin_transaction=1. address_data = current bus address. `len = min(burst_size+1, MAX_BURST, remaining)`. burst_size out = len-1. byte_enable=4'hF. read_n_write = ~direction.
  - Direction 1: sram_address = current SRAM address (prefetch of the first word).
  - Next state: READ_DATA or WRITE_DATA.
- READ_DATA: each cycle with busIn_data_valid=1 → sram_write_enable=1 with that beat at the current SRAM address. The SRAM address increments mod 512 and remaining decrements. busIn_end_transaction → GAP, or DONE if remaining==0.
- WRITE_DATA: data_valid=1 and address_data = current word, with no bubbles. A beat is accepted when `data_valid & ~busIn_busy`. The SRAM address for the next word is issued in the accept cycle, so the next word is presented in the following cycle. While busIn_busy is high, the word and data_valid are held. After len accepted beats → WRITE_END.
- WRITE_END (1 cycle): end_transaction=1, then GAP or DONE.
- GAP (1 cycle): request=0 to let other masters in, then REQUEST. The bus address advances by 4·len.
- busIn_error in any non-idle state: set error, drop all bus outputs next cycle, go to DONE. No further SRAM writes occur.
- DONE (1 cycle): done=1, busy=0 → IDLE.
- Width rules: SRAM address wraps 511→0. The bus address is 32-bit and wraps silently. remaining is 10-bit.

## Timing
- Reset values: every output 0, state IDLE, error 0. Asserting reset mid-transfer releases the bus immediately (asynchronously), with no end_transaction.
- Start to busOut_request: 1 cycle. Grant to begin_transaction: 1 cycle. Begin to first write beat: 1 cycle.
- Write throughput: 1 beat/cycle when not busy. Read throughput: limited by the slave.
- Done timing:
  - block_size==0: done 1 cycle after start.
  - Read: done 1 cycle after the final busIn_end_transaction.
  - Write: done 1 cycle after WRITE_END.
- Bus inputs are used in the cycle they are sampled; there is no extra input register stage.

## Test plan
- Read, block 8, burst 3 (4 beats): two bursts at 0x1000 and 0x1010, burst_size out=3, GAP between them. SRAM[0..7] equals the slave data; one done pulse; error=0.
- Write, block 5, burst 7, SRAM 0x1FE start: one burst with burst_size out=4. Words come from SRAM 0x1FE,0x1FF,0x000,0x001,0x002. end_transaction comes 1 cycle after the 5th accepted beat.
- Write with busIn_busy high on beats 2–3 for 3 cycles: data held stable, no beat lost or duplicated, 5 beats total.
- block_size=0: no request; done pulse at start+1.
- busIn_error on the 2nd read beat of 4: error=1, request drops next cycle, done pulse, only 1 SRAM write. A new start clears error.
- Reset asserted during WRITE_DATA: all bus outputs 0 immediately. After reset release the engine is IDLE; a new start runs normally.
